// File: rtl/hazard_pkg.sv
// Shared types for the hazard tag pipeline.
// stage_tag_t holds the per-instruction fields that travel down D/E/M/W.
// TAG_BUBBLE is the all-zero tag. A killed or empty slot therefore never
// drives a hazard-unit input high.
package hazard_pkg;

  localparam int AW_DEFAULT = 6;

  typedef struct packed {
    logic                  valid;
    logic [AW_DEFAULT-1:0] ra1;
    logic [AW_DEFAULT-1:0] ra2;
    logic [AW_DEFAULT-1:0] wa3;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  pcsrc;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_tag_pipe_if.sv
// Hazard-unit <-> tag-pipe interface.
//   master : hazard unit. It drives StallF/StallD/FlushD/FlushE and reads the stage tags.
//   slave  : tag pipe. It reads the stall/flush controls and drives the stage tags.
interface hazard_tag_pipe_if #(parameter int AW = 6) ();
  logic          StallF, StallD, FlushD, FlushE;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [AW-1:0] WA3E, WA3M, WA3W;
  logic          MemToRegE, RegWriteM, RegWriteW;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW;

  modport master (
    output StallF, StallD, FlushD, FlushE,
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  MemToRegE, RegWriteM, RegWriteW,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE,
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output MemToRegE, RegWriteM, RegWriteW,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW
  );
endinterface

// File: rtl/tag_stage_reg.sv
// One pipeline stage register for stage_tag_t.
//   clk, rst_n : clock and asynchronous active-low reset (reset value is the bubble)
//   en         : load enable. When low the register holds, and clr is ignored.
//   clr        : when enabled, load a bubble instead of d
//   d, q       : next and current stage tag
module tag_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  stage_tag_t d,
  output stage_tag_t q
);

  stage_tag_t tag_d, tag_q;

  // NOTE: default assignment first so every path assigns tag_d; no latch is inferred.
  always_comb begin
    tag_d = tag_q;
    if (en) tag_d = clr ? TAG_BUBBLE : d;
  end

  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= TAG_BUBBLE;
    else        tag_q <= tag_d;
  end

  assign q = tag_q;

endmodule

// File: rtl/hazard_tag_pipe.sv
// Carries the register tags and hazard-control bits of each instruction
// down the D/E/M/W stages. It obeys the stall and flush controls from the
// hazard unit and returns the stage tags to it. Every output is a register
// output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   valid_f, *_f         : instruction being latched into D
//   hz (slave)           : stall/flush in; RA*/WA*/RegWrite*/MemToRegE/PCSrc* out
//   retired_cnt          : valid instructions leaving W (wraps)
//   bubble_cnt           : bubbles leaving W (wraps)
//   stall_cnt            : cycles with StallF=1 (wraps)
// AW must equal hazard_pkg::AW_DEFAULT, because stage_tag_t fields are sized from it.
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_f,
  input  logic [AW-1:0] ra1_f,
  input  logic [AW-1:0] ra2_f,
  input  logic [AW-1:0] wa3_f,
  input  logic          regwrite_f,
  input  logic          memtoreg_f,
  input  logic          pcsrc_f,
  hazard_tag_pipe_if.slave hz,
  output logic [CW-1:0] retired_cnt,
  output logic [CW-1:0] bubble_cnt,
  output logic [CW-1:0] stall_cnt
);

  stage_tag_t f_tag, d_q, e_q, m_q, w_q;
  logic [CW-1:0] retired_d, retired_q, bubble_d, bubble_q, stall_d, stall_q;

  // An empty fetch slot enters D as a clean bubble. No stray tag bits come
  // in from the F inputs.
  always_comb begin
    f_tag = TAG_BUBBLE;
    if (valid_f) f_tag = '{valid: 1'b1, ra1: ra1_f, ra2: ra2_f, wa3: wa3_f,
                           regwrite: regwrite_f, memtoreg: memtoreg_f, pcsrc: pcsrc_f};
  end

  // StallD gates FlushD inside the stage register, so a stall wins over a flush.
  tag_stage_reg u_d (.clk, .rst_n, .en(~hz.StallD), .clr(hz.FlushD), .d(f_tag), .q(d_q));
  tag_stage_reg u_e (.clk, .rst_n, .en(1'b1),       .clr(hz.FlushE), .d(d_q),   .q(e_q));
  tag_stage_reg u_m (.clk, .rst_n, .en(1'b1),       .clr(1'b0),      .d(e_q),   .q(m_q));
  tag_stage_reg u_w (.clk, .rst_n, .en(1'b1),       .clr(1'b0),      .d(m_q),   .q(w_q));

  assign hz.RA1D      = d_q.ra1;
  assign hz.RA2D      = d_q.ra2;
  assign hz.PCSrcD    = d_q.pcsrc;
  assign hz.RA1E      = e_q.ra1;
  assign hz.RA2E      = e_q.ra2;
  assign hz.WA3E      = e_q.wa3;
  assign hz.MemToRegE = e_q.memtoreg;
  assign hz.PCSrcE    = e_q.pcsrc;
  assign hz.WA3M      = m_q.wa3;
  assign hz.RegWriteM = m_q.regwrite;
  assign hz.PCSrcM    = m_q.pcsrc;
  assign hz.WA3W      = w_q.wa3;
  assign hz.RegWriteW = w_q.regwrite;
  assign hz.PCSrcW    = w_q.pcsrc;

  // The W source tags and the load flag are dead once the instruction retires.
  logic unused_w;
  assign unused_w = ^{w_q.ra1, w_q.ra2, w_q.memtoreg};

  // The slot leaving W on this edge is either a retire or a bubble. So
  // retired + bubble counts every cycle since reset.
  always_comb begin
    retired_d = retired_q;
    bubble_d  = bubble_q;
    stall_d   = stall_q;
    if (w_q.valid) retired_d = retired_q + CW'(1);
    else           bubble_d  = bubble_q  + CW'(1);
    if (hz.StallF) stall_d   = stall_q   + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      bubble_q  <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
module tb_hazard_tag_pipe;
  import hazard_pkg::*;

  localparam int AW = AW_DEFAULT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_f = 1'b0;
  logic [AW-1:0] ra1_f = '0, ra2_f = '0, wa3_f = '0;
  logic          regwrite_f = 1'b0, memtoreg_f = 1'b0, pcsrc_f = 1'b0;
  logic [31:0]   retired_cnt, bubble_cnt, stall_cnt;
  logic [3:0]    retired4, bubble4, stall4;

  hazard_tag_pipe_if #(.AW(AW)) hz ();
  hazard_tag_pipe_if #(.AW(AW)) hz4 ();

  hazard_tag_pipe #(.AW(AW), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .ra1_f(ra1_f), .ra2_f(ra2_f),
    .wa3_f(wa3_f), .regwrite_f(regwrite_f), .memtoreg_f(memtoreg_f), .pcsrc_f(pcsrc_f),
    .hz(hz), .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance. It sees the same stimulus and exercises counter wrap.
  hazard_tag_pipe #(.AW(AW), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .ra1_f(ra1_f), .ra2_f(ra2_f),
    .wa3_f(wa3_f), .regwrite_f(regwrite_f), .memtoreg_f(memtoreg_f), .pcsrc_f(pcsrc_f),
    .hz(hz4), .retired_cnt(retired4), .bubble_cnt(bubble4), .stall_cnt(stall4)
  );

  always #5 clk = ~clk;

  // The hazard unit must never stall D while letting E copy it.
  always @(posedge clk)
    if (rst_n) assert (!(hz.StallD && !hz.FlushE))
      else $error("StallD=1 with FlushE=0 duplicates D into E");

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v; int unsigned ra1, ra2, wa3; bit rw, mr, pc;
  } instr_t;

  typedef struct {
    int unsigned ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    bit mr_e, rw_m, rw_w, pc_d, pc_e, pc_m, pc_w;
    longint unsigned ret, bub, stl;
  } exp_t;

  instr_t          pipe [4];   // 0=D 1=E 2=M 3=W
  longint unsigned n_ret = 0, n_bub = 0, n_stall = 0;
  exp_t            sb [$];

  task automatic step(input bit rst, input bit v, input int unsigned a1, input int unsigned a2,
                      input int unsigned a3, input bit rw, input bit mr, input bit pc,
                      input bit sf, input bit sd, input bit fd, input bit fe);
    instr_t bub, nf;
    exp_t   e;
    @(negedge clk);
    rst_n = rst; valid_f = v;
    ra1_f = AW'(a1); ra2_f = AW'(a2); wa3_f = AW'(a3);
    regwrite_f = rw; memtoreg_f = mr; pcsrc_f = pc;
    hz.StallF = sf;  hz.StallD = sd;  hz.FlushD = fd;  hz.FlushE = fe;
    hz4.StallF = sf; hz4.StallD = sd; hz4.FlushD = fd; hz4.FlushE = fe;
    bub = '{default: 0};
    nf  = '{v: 1'b1, ra1: a1, ra2: a2, wa3: a3, rw: rw, mr: mr, pc: pc};
    if (!rst) begin
      foreach (pipe[i]) pipe[i] = bub;
      n_ret = 0; n_bub = 0; n_stall = 0;
    end else begin
      if (pipe[3].v) n_ret++; else n_bub++;
      if (sf) n_stall++;
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = fe ? bub : pipe[0];
      if (!sd) pipe[0] = (fd || !v) ? bub : nf;
    end
    e.ra1d = pipe[0].ra1; e.ra2d = pipe[0].ra2; e.pc_d = pipe[0].pc;
    e.ra1e = pipe[1].ra1; e.ra2e = pipe[1].ra2; e.wa3e = pipe[1].wa3;
    e.mr_e = pipe[1].mr;  e.pc_e = pipe[1].pc;
    e.wa3m = pipe[2].wa3; e.rw_m = pipe[2].rw;  e.pc_m = pipe[2].pc;
    e.wa3w = pipe[3].wa3; e.rw_w = pipe[3].rw;  e.pc_w = pipe[3].pc;
    e.ret = n_ret; e.bub = n_bub; e.stl = n_stall;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("RA1D", hz.RA1D, e.ra1d);
        check("RA2D", hz.RA2D, e.ra2d);
        check("RA1E", hz.RA1E, e.ra1e);
        check("RA2E", hz.RA2E, e.ra2e);
        check("WA3E", hz.WA3E, e.wa3e);
        check("WA3M", hz.WA3M, e.wa3m);
        check("WA3W", hz.WA3W, e.wa3w);
        check("MemToRegE", hz.MemToRegE, e.mr_e);
        check("RegWriteM", hz.RegWriteM, e.rw_m);
        check("RegWriteW", hz.RegWriteW, e.rw_w);
        check("PCSrcDEMW", {hz.PCSrcD, hz.PCSrcE, hz.PCSrcM, hz.PCSrcW},
              {e.pc_d, e.pc_e, e.pc_m, e.pc_w});
        check("retired_cnt", retired_cnt, e.ret & 64'hFFFF_FFFF);
        check("bubble_cnt", bubble_cnt, e.bub & 64'hFFFF_FFFF);
        check("stall_cnt", stall_cnt, e.stl & 64'hFFFF_FFFF);
        check("retired_cnt_cw4", retired4, e.ret & 64'hF);
        check("bubble_cnt_cw4", bubble4, e.bub & 64'hF);
        check("stall_cnt_cw4", stall4, e.stl & 64'hF);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    hz.StallF = 0;  hz.StallD = 0;  hz.FlushD = 0;  hz.FlushE = 0;
    hz4.StallF = 0; hz4.StallD = 0; hz4.FlushD = 0; hz4.FlushE = 0;
    foreach (pipe[i]) pipe[i] = '{default: 0};
    #1;
    check("reset_RA1D", hz.RA1D, 0);
    check("reset_WA3W", hz.WA3W, 0);
    check("reset_retired", retired_cnt, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Straight flow: a single ra1=1 ra2=2 wa3=3 regwrite instruction.
    step(1, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Load-use stall: load in D, dependent in F, one stall cycle.
    step(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 6, 1, 0, 0, 1, 1, 0, 1);
    step(1, 1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Branch flush: pcsrc instruction reaches E, then its two younger ones are killed.
    step(1, 1, 1, 1, 10, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 2, 2, 11, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 3, 12, 1, 0, 0, 0, 0, 1, 1);
    idle(5);

    // Stall beats flush.
    step(1, 1, 7, 9, 4, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1);
    idle(4);

    // Wrap: a fresh run of 20 back-to-back valid instructions from reset
    // takes the CW=4 retire counter past 16.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, i % 64, (i + 1) % 64, (i + 2) % 64, 1, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic under hazard-unit-legal controls.
    for (int i = 0; i < 400; i++) begin
      bit sd, fe, fd, sf;
      sd = ($urandom_range(7) == 0);
      fe = sd | ($urandom_range(7) == 0);
      fd = ($urandom_range(7) == 0);
      sf = sd | ($urandom_range(9) == 0);
      step(1, $urandom_range(3) != 0, $urandom_range(63), $urandom_range(63), $urandom_range(63),
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), sf, sd, fd, fe);
    end

    // Mid-run reset with valid tags in every stage: the clear is immediate.
    for (int i = 0; i < 4; i++) step(1, 1, 33 + i, 34 + i, 35 + i, 1, 1, 1, 1, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_RA1D", hz.RA1D, 0);
    check("async_rst_RA1E", hz.RA1E, 0);
    check("async_rst_WA3M", hz.WA3M, 0);
    check("async_rst_WA3W", hz.WA3W, 0);
    check("async_rst_ctrl", {hz.MemToRegE, hz.RegWriteM, hz.RegWriteW, hz.PCSrcW}, 0);
    check("async_rst_retired", retired_cnt, 0);
    check("async_rst_stall", stall_cnt, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
